// File: rtl/bp_fe_trace_replay_be_if.sv
// FE queue / FE command handshake bundle between the front end and the replay back end.
// master = back end (consumes queue entries, issues redirects); slave = front end.
interface bp_fe_trace_replay_be_if #(
    parameter int vaddr_width_p = 39
);
    logic [vaddr_width_p-1:0] fe_queue_pc;
    logic                     fe_queue_v;
    logic                     fe_queue_ready;
    logic [vaddr_width_p-1:0] fe_cmd_pc;
    logic                     fe_cmd_v;
    logic                     fe_cmd_ready;

    modport master (
        input  fe_queue_pc,
        input  fe_queue_v,
        output fe_queue_ready,
        output fe_cmd_pc,
        output fe_cmd_v,
        input  fe_cmd_ready
    );

    modport slave (
        output fe_queue_pc,
        output fe_queue_v,
        input  fe_queue_ready,
        input  fe_cmd_pc,
        input  fe_cmd_v,
        output fe_cmd_ready
    );
endinterface

// File: rtl/bp_fe_trace_replay_be.sv
// Mock back end for FE-only benches: walks a trace ROM of EXPECT/REDIRECT/STALL/END ops,
// checks queue PCs, drives redirects, and reports done/fail with mismatch and retire counts.
module bp_fe_trace_replay_be #(
    parameter int vaddr_width_p      = 39,
    parameter int trace_addr_width_p = 10,
    parameter int stall_width_p      = 8,
    parameter int timeout_p          = 1024,
    parameter int stop_on_mismatch_p = 1,
    localparam int trace_data_width_lp = 2 + vaddr_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    output logic [trace_addr_width_p-1:0]  trace_addr_o,
    input  logic [trace_data_width_lp-1:0] trace_data_i,
    bp_fe_trace_replay_be_if.master        fe_if,
    output logic                           done_o,
    output logic                           fail_o,
    output logic [15:0]                    mismatch_count_o,
    output logic [31:0]                    instr_count_o
);

    localparam logic [1:0] OP_EXPECT   = 2'b00;
    localparam logic [1:0] OP_REDIRECT = 2'b01;
    localparam logic [1:0] OP_STALL    = 2'b10;
    localparam logic [1:0] OP_END      = 2'b11;

    localparam bit stop_lp = (stop_on_mismatch_p != 0);

    // Watchdog only has to represent 0 .. timeout_p-1; reaching the last value without progress fails.
    localparam int wd_w_lp = (timeout_p < 2) ? 1 : $clog2(timeout_p);
    localparam logic [wd_w_lp-1:0]            wd_last_lp   = wd_w_lp'(timeout_p - 1);
    localparam logic [wd_w_lp-1:0]            wd_one_lp    = wd_w_lp'(1);
    localparam logic [trace_addr_width_p-1:0] addr_one_lp  = trace_addr_width_p'(1);
    localparam logic [stall_width_p-1:0]      stall_one_lp = stall_width_p'(1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STALL,
        DONE,
        FAIL
    } state_e;

    state_e                        state_r;
    logic [trace_addr_width_p-1:0] trace_addr_r;
    logic [stall_width_p-1:0]      stall_cnt_r;
    logic [wd_w_lp-1:0]            wd_cnt_r;
    logic [31:0]                   instr_cnt_r;
    logic [15:0]                   mism_cnt_r;

    logic [1:0]               op;
    logic [vaddr_width_p-1:0] arg;
    logic [stall_width_p-1:0] stall_n;
    logic                     in_run;
    logic                     queue_ready;
    logic                     cmd_v;
    logic                     pc_match;
    logic                     exp_fire;
    logic                     mismatch;
    logic                     run_adv;
    logic                     stall_last;
    logic                     advance;
    logic                     at_last;
    logic                     overrun;
    logic                     wd_expire;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign op      = trace_data_i[trace_data_width_lp-1 -: 2];
    assign arg     = trace_data_i[vaddr_width_p-1:0];
    assign stall_n = arg[stall_width_p-1:0];

    // Handshake outputs depend only on state and the ROM word, never on the FE's ready/valid.
    assign in_run      = (state_r == RUN);
    assign queue_ready = in_run && (op == OP_EXPECT);
    assign cmd_v       = in_run && (op == OP_REDIRECT);

    assign pc_match = (fe_if.fe_queue_pc == arg);
    assign exp_fire = queue_ready && fe_if.fe_queue_v;
    assign mismatch = exp_fire && !pc_match;

    assign run_adv = (exp_fire && (pc_match || !stop_lp))
                   || (cmd_v && fe_if.fe_cmd_ready)
                   || (in_run && (op == OP_STALL) && (stall_n == '0));
    assign stall_last = (state_r == STALL) && (stall_cnt_r == stall_one_lp);
    assign advance    = run_adv || stall_last;

    // The address never wraps: stepping past the last ROM entry is an overrun.
    assign at_last   = &trace_addr_r;
    assign overrun   = advance && at_last;
    assign wd_expire = in_run && !advance && (wd_cnt_r == wd_last_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            trace_addr_r <= '0;
            stall_cnt_r  <= '0;
            wd_cnt_r     <= '0;
            instr_cnt_r  <= '0;
            mism_cnt_r   <= '0;
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_r  <= RUN;
                        wd_cnt_r <= '0;
                    end
                end
                RUN: begin
                    if (exp_fire && pc_match)
                        instr_cnt_r <= instr_cnt_r + 32'd1;
                    if (mismatch)
                        mism_cnt_r <= sat_inc16(mism_cnt_r);
                    wd_cnt_r <= advance ? '0 : wd_cnt_r + wd_one_lp;
                    if (advance && !at_last)
                        trace_addr_r <= trace_addr_r + addr_one_lp;
                    if (op == OP_END)
                        state_r <= DONE;
                    else if (overrun || (mismatch && stop_lp) || wd_expire)
                        state_r <= FAIL;
                    else if ((op == OP_STALL) && (stall_n != '0)) begin
                        state_r     <= STALL;
                        stall_cnt_r <= stall_n;
                    end
                end
                STALL: begin
                    stall_cnt_r <= stall_cnt_r - stall_one_lp;
                    if (stall_last) begin
                        wd_cnt_r <= '0;
                        if (at_last)
                            state_r <= FAIL;
                        else begin
                            trace_addr_r <= trace_addr_r + addr_one_lp;
                            state_r      <= RUN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign trace_addr_o         = trace_addr_r;
    assign fe_if.fe_queue_ready = queue_ready;
    assign fe_if.fe_cmd_v       = cmd_v;
    assign fe_if.fe_cmd_pc      = cmd_v ? arg : '0;
    assign done_o               = (state_r == DONE);
    assign fail_o               = (state_r == FAIL);
    assign mismatch_count_o     = mism_cnt_r;
    assign instr_count_o        = instr_cnt_r;

endmodule
